// File: rtl/rotating_doors_monitor_pkg.sv
// rtl/rotating_doors_monitor_pkg.sv - shared door mode, state and fault-code definitions
package rotating_doors_pkg;

    // Door mode encodings, shared with the rotating-door driver
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_NEARBY = 2'b01,
        MODE_INSIDE = 2'b10,
        MODE_STUCK  = 2'b11
    } door_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        TRACK = 2'b10
    } mon_state_e;

    localparam logic [1:0] FAULT_PATTERN = 2'b01;
    localparam logic [1:0] FAULT_STEP    = 2'b10;
    localparam logic [1:0] FAULT_FAST    = 2'b11;

    // Successor position in the a..f ring, wrapping f back to a
    function automatic logic [2:0] next_pos(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rotating_doors_monitor_if.sv
// rtl/rotating_doors_monitor_if.sv - rotation lines and monitor status bundle
interface rotating_doors_monitor_if #(
    parameter int CNT_W = 8
);
    logic             a, b, c, d, e, f;
    logic [2:0]       pos;
    logic             pos_valid;
    logic             step;
    logic [1:0]       mode;
    logic             mode_valid;
    logic [CNT_W-1:0] dwell;
    logic             fault;
    logic [1:0]       fault_code;
    logic [7:0]       fault_cnt;

    modport master (
        output a, b, c, d, e, f,
        input  pos, pos_valid, step, mode, mode_valid, dwell, fault, fault_code, fault_cnt
    );

    modport slave (
        input  a, b, c, d, e, f,
        output pos, pos_valid, step, mode, mode_valid, dwell, fault, fault_code, fault_cnt
    );
endinterface

// File: rtl/rotating_doors_monitor_decode.sv
// rtl/rotating_doors_monitor_decode.sv - one-hot-low rotation pattern decoder
module door_pattern_decode (
    input  logic [5:0] lines,
    output logic [2:0] pos,
    output logic       valid
);
    logic [2:0] zeros;

    // Count low lines and report the index of the low one
    always_comb begin
        pos   = 3'd0;
        zeros = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!lines[i]) begin
                zeros = zeros + 3'd1;
                pos   = i[2:0];
            end
        end
        valid = (zeros == 3'd1);
    end
endmodule

// File: rtl/rotating_doors_monitor.sv
// rtl/rotating_doors_monitor.sv - rotation sequence checker, dwell meter and mode classifier
module rotating_doors_monitor #(
    parameter int MIN_DWELL     = 2,
    parameter int NORMAL_MAX    = 4,
    parameter int INSIDE_MAX    = 7,
    parameter int STUCK_TIMEOUT = 32,
    parameter int CNT_W         = 8
) (
    input logic                   clk,
    input logic                   rst,
    rotating_doors_monitor_if.slave bus
);
    import rotating_doors_pkg::*;

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_DWELL);
    localparam logic [CNT_W-1:0] NORMAL_C = CNT_W'(NORMAL_MAX);
    localparam logic [CNT_W-1:0] INSIDE_C = CNT_W'(INSIDE_MAX);
    localparam logic [CNT_W-1:0] STUCK_C  = CNT_W'(STUCK_TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [5:0]       smp;
    logic [2:0]       dec_pos;
    logic             dec_valid;

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
    logic [2:0]       pos_q, pos_d;
    logic             pos_valid_q, pos_valid_d, step_q, step_d;
    logic [1:0]       mode_q, mode_d, fault_code_q, fault_code_d;
    logic             mode_valid_q, mode_valid_d, fault_q, fault_d;
    logic [7:0]       fault_cnt_q, fault_cnt_d;
    logic             flt;
    logic [1:0]       flt_code;

    // Register the raw lines once; lines idle high so reset loads all-ones
    always_ff @(posedge clk) begin
        if (rst) smp <= 6'h3F;
        else     smp <= {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    end

    door_pattern_decode u_decode (
        .lines (smp),
        .pos   (dec_pos),
        .valid (dec_valid)
    );

    // State, dwell counter and all status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pos_q        <= 3'd0;
            pos_valid_q  <= 1'b0;
            step_q       <= 1'b0;
            mode_q       <= MODE_NORMAL;
            mode_valid_q <= 1'b0;
            dwell_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            fault_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            pos_valid_q  <= pos_valid_d;
            step_q       <= step_d;
            mode_q       <= mode_d;
            mode_valid_q <= mode_valid_d;
            dwell_q      <= dwell_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    // Next state: lock, track the ring, classify dwells, detect faults
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pos_d        = pos_q;
        pos_valid_d  = pos_valid_q;
        step_d       = 1'b0;
        mode_d       = mode_q;
        mode_valid_d = mode_valid_q;
        dwell_d      = dwell_q;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        fault_cnt_d  = fault_cnt_q;
        flt          = 1'b0;
        flt_code     = FAULT_PATTERN;

        case (state_q)
            IDLE: begin
                if (dec_valid) begin
                    pos_d       = dec_pos;
                    cnt_d       = ONE_C;
                    pos_valid_d = 1'b1;
                    state_d     = SYNC;
                end
            end
            default: begin
                if (!dec_valid) begin
                    flt      = 1'b1;
                    flt_code = FAULT_PATTERN;
                end else if (dec_pos == pos_q) begin
                    if (cnt_q < STUCK_C) cnt_d = cnt_q + ONE_C;
                    // Timeout fires once, on the edge the counter reaches the limit
                    if (cnt_q == STUCK_C - ONE_C) begin
                        mode_d       = MODE_STUCK;
                        mode_valid_d = 1'b1;
                        state_d      = TRACK;
                    end
                end else if (dec_pos == next_pos(pos_q)) begin
                    if (state_q == SYNC) begin
                        // First dwell was partial: just start measuring
                        pos_d   = dec_pos;
                        cnt_d   = ONE_C;
                        state_d = TRACK;
                    end else if (cnt_q < MIN_C) begin
                        flt      = 1'b1;
                        flt_code = FAULT_FAST;
                    end else begin
                        step_d       = 1'b1;
                        dwell_d      = cnt_q;
                        pos_d        = dec_pos;
                        cnt_d        = ONE_C;
                        mode_valid_d = 1'b1;
                        if (cnt_q <= NORMAL_C)      mode_d = MODE_NORMAL;
                        else if (cnt_q <= INSIDE_C) mode_d = MODE_INSIDE;
                        else if (cnt_q < STUCK_C)   mode_d = MODE_NEARBY;
                    end
                end else begin
                    flt      = 1'b1;
                    flt_code = FAULT_STEP;
                end
            end
        endcase

        if (flt) begin
            fault_d      = 1'b1;
            fault_code_d = flt_code;
            if (fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
            pos_valid_d  = 1'b0;
            mode_valid_d = 1'b0;
            cnt_d        = '0;
            state_d      = IDLE;
        end
    end

    assign bus.pos        = pos_q;
    assign bus.pos_valid  = pos_valid_q;
    assign bus.step       = step_q;
    assign bus.mode       = mode_q;
    assign bus.mode_valid = mode_valid_q;
    assign bus.dwell      = dwell_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fault_code_q;
    assign bus.fault_cnt  = fault_cnt_q;
endmodule

// File: tb/tb_rotating_doors_monitor.sv
// tb/tb_rotating_doors_monitor.sv - scoreboard bench for rotating_doors_monitor
module tb_rotating_doors_monitor;

    typedef struct {
        int kind;   // 1 step, 2 fault
        int pos;
        int dwell;
        int mode;
        int code;
        int fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic prev_step = 1'b0;

    rotating_doors_monitor_if #(.CNT_W(8)) bus ();

    rotating_doors_monitor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] pat(input int k);
        logic [5:0] one;
        one = 6'b000001;
        return ~(one << k);
    endfunction

    task automatic set_lines(input logic [5:0] p);
        {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = p;
    endtask

    // Drive a pattern for n clocks; optionally expect one step (1) or fault (2) from it
    task automatic seg(input logic [5:0] p, input int n, input int kind, input int epos,
                       input int edwell, input int emode, input int ecode, input int efcnt);
        exp_t x;
        if (kind != 0) begin
            x.kind = kind; x.pos = epos; x.dwell = edwell;
            x.mode = emode; x.code = ecode; x.fcnt = efcnt;
            exp_q.push_back(x);
        end
        set_lines(p);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pos"},        bus.pos,        0);
        chk({tag, "_pos_valid"},  bus.pos_valid,  0);
        chk({tag, "_step"},       bus.step,       0);
        chk({tag, "_mode"},       bus.mode,       0);
        chk({tag, "_mode_valid"}, bus.mode_valid, 0);
        chk({tag, "_dwell"},      bus.dwell,      0);
        chk({tag, "_fault"},      bus.fault,      0);
        chk({tag, "_fault_code"}, bus.fault_code, 0);
        chk({tag, "_fault_cnt"},  bus.fault_cnt,  0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a step or fault
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (prev_step) chk("step_one_cycle", bus.step, 0);
            if (bus.step || bus.fault) begin
                if (exp_q.size() == 0) begin
                    chk("event_expected", exp_q.size(), 1);
                end else begin
                    x = exp_q.pop_front();
                    chk("ev_step",      bus.step,      (x.kind == 1) ? 1 : 0);
                    chk("ev_fault",     bus.fault,     (x.kind == 2) ? 1 : 0);
                    chk("ev_pos",       bus.pos,       x.pos);
                    chk("ev_dwell",     bus.dwell,     x.dwell);
                    chk("ev_mode",      bus.mode,      x.mode);
                    chk("ev_mode_valid", bus.mode_valid, (x.kind == 1) ? 1 : 0);
                    chk("ev_pos_valid", bus.pos_valid, (x.kind == 1) ? 1 : 0);
                    chk("ev_fault_cnt", bus.fault_cnt, x.fcnt);
                    if (x.kind == 2) chk("ev_fault_code", bus.fault_code, x.code);
                end
            end
            prev_step = bus.step;
        end else begin
            prev_step = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_lines(6'h3F);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst = 1'b0;

        // Lock on a, pos_valid two edges after the first valid pattern
        seg(pat(0), 1, 0, 0, 0, 0, 0, 0);
        chk("pv_edge1", bus.pos_valid, 0);
        seg(pat(0), 1, 0, 0, 0, 0, 0, 0);
        chk("pv_edge2", bus.pos_valid, 1);
        chk("pos_lock_a", bus.pos, 0);
        seg(pat(0), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(1), 5, 0, 0, 0, 0, 0, 0);
        chk("mode_valid_sync", bus.mode_valid, 0);
        seg(pat(2), 5, 1, 2, 5, 2, 0, 0);
        seg(pat(3), 10, 1, 3, 5, 2, 0, 0);
        // 10-clock dwells, including the f->a wrap
        seg(pat(4), 10, 1, 4, 10, 1, 0, 0);
        seg(pat(5), 10, 1, 5, 10, 1, 0, 0);
        seg(pat(0), 10, 1, 0, 10, 1, 0, 0);
        seg(pat(1), 10, 1, 1, 10, 1, 0, 0);
        seg(pat(2), 10, 1, 2, 10, 1, 0, 0);
        seg(pat(3), 10, 1, 3, 10, 1, 0, 0);
        seg(pat(4), 10, 1, 4, 10, 1, 0, 0);
        seg(pat(5), 10, 1, 5, 10, 1, 0, 0);
        chk("no_fault_wrap", bus.fault_cnt, 0);
        // 3/4-clock dwells -> NORMAL
        seg(pat(0), 3, 1, 0, 10, 1, 0, 0);
        seg(pat(1), 4, 1, 1, 3, 0, 0, 0);
        seg(pat(2), 3, 1, 2, 4, 0, 0, 0);
        // Freeze on d: STUCK exactly when the counter reaches 32
        seg(pat(3), 32, 1, 3, 3, 0, 0, 0);
        chk("pre_stuck_mode", bus.mode, 0);
        seg(pat(3), 1, 0, 0, 0, 0, 0, 0);
        chk("stuck_mode", bus.mode, 3);
        chk("stuck_mode_valid", bus.mode_valid, 1);
        seg(pat(3), 7, 0, 0, 0, 0, 0, 0);
        chk("stuck_hold", bus.mode, 3);
        // First step after stuck keeps STUCK, the next one reclassifies
        seg(pat(4), 10, 1, 4, 32, 3, 0, 0);
        seg(pat(5), 10, 1, 5, 10, 1, 0, 0);
        // Two lines low in TRACK -> bad pattern; same pattern in IDLE -> ignored
        seg(6'b110011, 5, 2, 5, 10, 1, 1, 1);
        chk("idle_bad_ignored", bus.fault_cnt, 1);
        chk("idle_pos_valid", bus.pos_valid, 0);
        // Skip c->e and backward c->b
        seg(pat(2), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(4), 1, 2, 2, 10, 1, 2, 2);
        seg(pat(2), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(1), 1, 2, 2, 10, 1, 2, 3);
        // One-clock dwell in TRACK -> too fast
        seg(pat(2), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(3), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(4), 1, 1, 4, 3, 0, 0, 3);
        seg(pat(5), 3, 2, 4, 3, 0, 3, 4);
        chk("fast_code_hold", bus.fault_code, 3);
        // Relock to NEARBY, then reset pulse mid-TRACK
        seg(pat(0), 10, 0, 0, 0, 0, 0, 0);
        seg(pat(1), 10, 1, 1, 10, 1, 0, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("rst1");
        rst = 1'b0;
        seg(pat(1), 1, 0, 0, 0, 0, 0, 0);
        chk("relock_pv1", bus.pos_valid, 0);
        seg(pat(1), 1, 0, 0, 0, 0, 0, 0);
        chk("relock_pv2", bus.pos_valid, 1);
        seg(pat(1), 3, 0, 0, 0, 0, 0, 0);
        seg(pat(2), 5, 0, 0, 0, 0, 0, 0);
        chk("relock_mode_valid", bus.mode_valid, 0);
        chk("relock_pos", bus.pos, 2);
        seg(pat(3), 5, 1, 3, 5, 2, 0, 0);
        seg(pat(4), 3, 1, 4, 5, 2, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("events_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
